// File: rtl/jt12_kon_pkg.sv
// -----------------------------------------------------------------------------
// jt12_kon_pkg
// Shared definitions for the key-on write scheduler:
//   - kon_state_e    : scheduler FSM state encoding (IDLE, WAIT)
//   - ENTRY_W        : width of one queued key-on entry {op_mask[3:0], ch[2:0]}
//   - commit-slot constants for the 6-channel and 3-channel variants
//   - invalid-channel masks (bit N set => channel code N is not a real channel)
// -----------------------------------------------------------------------------
package jt12_kon_pkg;

  localparam int ENTRY_W = 7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } kon_state_e;

  // Slot at which the key-on block commits its staged value.
  localparam logic [1:0] COMMIT_OP     = 2'd3;
  localparam logic [2:0] COMMIT_CH_6CH = 3'd6;
  localparam logic [2:0] COMMIT_CH_3CH = 3'd2;

  // 6-channel parts skip codes 3 and 7; 3-channel parts only use codes 0..2.
  localparam logic [7:0] INVALID_MASK_6CH = 8'b1000_1000;
  localparam logic [7:0] INVALID_MASK_3CH = 8'b1111_1000;

  function automatic logic [7:0] invalid_mask(input int n_ch);
    return (n_ch == 3) ? INVALID_MASK_3CH : INVALID_MASK_6CH;
  endfunction

  function automatic logic [2:0] commit_ch(input int n_ch);
    return (n_ch == 3) ? COMMIT_CH_3CH : COMMIT_CH_6CH;
  endfunction

endpackage

// File: rtl/jt12_kon_fifo.sv
// -----------------------------------------------------------------------------
// jt12_kon_fifo
// DEPTH x WIDTH synchronous FIFO holding pending key-on entries.
// Ports:
//   clk, rst_n (async, active-low), clk_en (all state advances only when high)
//   push / din   : write an entry (accepted when not full, or when full and a
//                  pop happens in the same cycle)
//   pop          : remove the head entry (ignored when empty)
//   dout         : current head entry (valid while !empty)
//   empty, full  : occupancy flags
// Handshake: push/pop are single-cycle strobes qualified by clk_en; dout is
// the registered head, there is no push-to-dout bypass.
// -----------------------------------------------------------------------------
module jt12_kon_fifo
  import jt12_kon_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ENTRY_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign pop_ok  = clk_en && pop && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok = clk_en && push && (!full || pop_ok);

  assign dout = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/jt12_kon_sched.sv
// -----------------------------------------------------------------------------
// jt12_kon_sched
// Key-on write scheduler. Queues decoded register-0x28 writes and hands them
// to the key-on shift-register block at most once per slot frame, so that no
// staged key-on value is overwritten before its commit slot.
// Ports:
//   clk, rst_n (async, active-low), clk_en (state advances only when high)
//   wr_en, din[7:0]     : CPU write to 0x28; din[7:4] op mask, din[2:0] channel
//   next_op, next_ch    : slot counter position, used to detect the commit slot
//   clr_ovf             : clears the sticky overflow flag
//   keyon_op, keyon_ch  : entry being issued (held between pulses)
//   up_keyon            : one-clk_en-cycle issue pulse
//   busy                : queue non-empty or waiting for a commit
//   full                : queue holds depth entries
//   ovf                 : sticky, a valid write was dropped on a full queue
// Handshake: the consumer samples keyon_op/keyon_ch while up_keyon is high;
// the next pulse is held back until the commit slot has passed with
// up_keyon low, which guarantees the previous value was committed.
// -----------------------------------------------------------------------------
module jt12_kon_sched
  import jt12_kon_pkg::*;
#(
  parameter int num_ch = 6,
  parameter int depth  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en,
  input  logic       wr_en,
  input  logic [7:0] din,
  input  logic [1:0] next_op,
  input  logic [2:0] next_ch,
  input  logic       clr_ovf,
  output logic [3:0] keyon_op,
  output logic [2:0] keyon_ch,
  output logic       up_keyon,
  output logic       busy,
  output logic       full,
  output logic       ovf
);

  localparam logic [7:0] INV_MASK = invalid_mask(num_ch);
  localparam logic [2:0] CMT_CH   = commit_ch(num_ch);

  kon_state_e          state_q, state_d;
  logic                up_keyon_q, up_keyon_d;
  logic [3:0]          keyon_op_q, keyon_op_d;
  logic [2:0]          keyon_ch_q, keyon_ch_d;
  logic                ovf_q, ovf_d;

  logic                wr_valid;
  logic                commit;
  logic                fifo_push;
  logic                fifo_pop;
  logic [ENTRY_W-1:0]  fifo_dout;
  logic                fifo_empty;
  logic                fifo_full;
  logic                drop;
  logic                din_unused;

  // din[3] is not part of the key-on command.
  assign din_unused = din[3];

  assign wr_valid = clk_en && wr_en && !INV_MASK[din[2:0]];
  assign commit   = (next_ch == CMT_CH) && (next_op == COMMIT_OP);

  assign fifo_push = wr_valid && (!fifo_full || fifo_pop);
  assign drop      = wr_valid && fifo_full && !fifo_pop;

  jt12_kon_fifo #(
    .DEPTH (depth),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (clk_en),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .din    ({din[7:4], din[2:0]}),
    .dout   (fifo_dout),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  // Issue FSM. The pulse lasts exactly one clk_en cycle; in WAIT a commit
  // seen while the pulse is still high is ignored because the consumer is
  // still committing its previous staged value at that slot.
  always_comb begin
    state_d    = state_q;
    up_keyon_d = up_keyon_q;
    keyon_op_d = keyon_op_q;
    keyon_ch_d = keyon_ch_q;
    fifo_pop   = 1'b0;
    if (clk_en) begin
      up_keyon_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            up_keyon_d = 1'b1;
            keyon_op_d = fifo_dout[6:3];
            keyon_ch_d = fifo_dout[2:0];
            state_d    = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (commit && !up_keyon_q) begin
            if (!fifo_empty) begin
              fifo_pop   = 1'b1;
              up_keyon_d = 1'b1;
              keyon_op_d = fifo_dout[6:3];
              keyon_ch_d = fifo_dout[2:0];
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_comb begin
    ovf_d = ovf_q;
    if (clk_en) begin
      if (clr_ovf) ovf_d = 1'b0;
      if (drop)    ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      up_keyon_q <= 1'b0;
      keyon_op_q <= '0;
      keyon_ch_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      up_keyon_q <= up_keyon_d;
      keyon_op_q <= keyon_op_d;
      keyon_ch_q <= keyon_ch_d;
      ovf_q      <= ovf_d;
    end
  end

  assign keyon_op = keyon_op_q;
  assign keyon_ch = keyon_ch_q;
  assign up_keyon = up_keyon_q;
  assign ovf      = ovf_q;
  assign full     = fifo_full;
  assign busy     = !fifo_empty || (state_q == ST_WAIT);

endmodule

// File: tb/tb_jt12_kon_sched.sv
// -----------------------------------------------------------------------------
// tb_jt12_kon_sched
// Directed bench for jt12_kon_sched. Two instances share all inputs: dut6
// (num_ch=6) and dut3 (num_ch=3). The bench models the slot counter as a
// 0..23 position: op = pos/6, ch = {0,1,2,4,5,6}[pos%6], so the 6-channel
// commit slot is position 23 and the 3-channel commit slot is position 20.
// -----------------------------------------------------------------------------
module tb_jt12_kon_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clk_en;
  logic       wr_en;
  logic [7:0] din;
  logic [1:0] next_op;
  logic [2:0] next_ch;
  logic       clr_ovf;

  logic [3:0] op6, op3;
  logic [2:0] ch6, ch3;
  logic       up6, up3, busy6, busy3, full6, full3, ovf6, ovf3;

  int n_cmp = 0;
  int n_err = 0;
  int slot  = 0;
  bit slot_run = 1'b0;
  int p6, p3;

  always #5 clk = ~clk;

  jt12_kon_sched #(.num_ch(6), .depth(4)) dut6 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .wr_en(wr_en), .din(din),
    .next_op(next_op), .next_ch(next_ch), .clr_ovf(clr_ovf),
    .keyon_op(op6), .keyon_ch(ch6), .up_keyon(up6), .busy(busy6),
    .full(full6), .ovf(ovf6)
  );

  jt12_kon_sched #(.num_ch(3), .depth(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .wr_en(wr_en), .din(din),
    .next_op(next_op), .next_ch(next_ch), .clr_ovf(clr_ovf),
    .keyon_op(op3), .keyon_ch(ch3), .up_keyon(up3), .busy(busy3),
    .full(full3), .ovf(ovf3)
  );

  function automatic logic [2:0] slot_ch(input int s);
    case (s % 6)
      0: return 3'd0;
      1: return 3'd1;
      2: return 3'd2;
      3: return 3'd4;
      4: return 3'd5;
      default: return 3'd6;
    endcase
  endfunction

  task automatic drive_slot();
    next_op = 2'(slot / 6);
    next_ch = slot_ch(slot);
  endtask

  // One clock: inputs set before the edge are sampled, outputs read at +1.
  task automatic tick();
    @(posedge clk);
    #1;
    if (slot_run) slot = (slot + 1) % 24;
    drive_slot();
  endtask

  task automatic wr(input logic [7:0] d);
    wr_en = 1'b1;
    din   = d;
    tick();
    wr_en = 1'b0;
    din   = 8'h00;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic count_pulses(input int n, output int c6, output int c3);
    c6 = 0;
    c3 = 0;
    repeat (n) begin
      tick();
      if (up6) c6++;
      if (up3) c3++;
    end
  endtask

  task automatic goto_slot(input int s);
    int g;
    g = 0;
    while (slot != s && g < 30) begin
      tick();
      g++;
    end
    if (slot != s) begin
      n_cmp++;
      n_err++;
      $display("FAIL goto_slot: observed %0d expected %0d", slot, s);
    end
  endtask

  logic [7:0] drain_exp [4];

  initial begin
    rst_n   = 1'b0;
    clk_en  = 1'b1;
    wr_en   = 1'b0;
    clr_ovf = 1'b0;
    din     = 8'h00;
    drive_slot();
    drain_exp[0] = 8'h11;
    drain_exp[1] = 8'h22;
    drain_exp[2] = 8'h44;
    drain_exp[3] = 8'h85;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_up",   32'(up6),   32'h0);
    chk("rst_op",   32'(op6),   32'h0);
    chk("rst_ch",   32'(ch6),   32'h0);
    chk("rst_ovf",  32'(ovf6),  32'h0);
    chk("rst_busy", 32'(busy6), 32'h0);
    chk("rst_full", 32'(full6), 32'h0);
    rst_n    = 1'b1;
    slot     = 0;
    slot_run = 1'b1;
    drive_slot();

    // Single write F1: pulse two cycles after the write
    wr(8'hF1);
    chk("t1_up_after_push", 32'(up6),   32'h0);
    chk("t1_busy",          32'(busy6), 32'h1);
    tick();
    chk("t1_up",  32'(up6), 32'h1);
    chk("t1_op",  32'(op6), 32'hF);
    chk("t1_ch",  32'(ch6), 32'h1);
    tick();
    chk("t1_up_end",  32'(up6),   32'h0);
    chk("t1_op_hold", 32'(op6),   32'hF);
    count_pulses(20, p6, p3);
    chk("t1_no_pulse",    32'(p6),    32'h0);
    chk("t1_busy_before", 32'(busy6), 32'h1);
    tick();
    chk("t1_busy_after_commit", 32'(busy6), 32'h0);

    // Three back-to-back writes, one issue per frame
    wr(8'h10);
    wr(8'h22);
    chk("t2_a_up", 32'(up6), 32'h1);
    chk("t2_a_op", 32'(op6), 32'h1);
    chk("t2_a_ch", 32'(ch6), 32'h0);
    wr(8'hF4);
    chk("t2_a_end", 32'(up6), 32'h0);
    count_pulses(20, p6, p3);
    chk("t2_gap_a", 32'(p6), 32'h0);
    tick();
    chk("t2_b_up", 32'(up6), 32'h1);
    chk("t2_b_op", 32'(op6), 32'h2);
    chk("t2_b_ch", 32'(ch6), 32'h2);
    count_pulses(23, p6, p3);
    chk("t2_gap_b", 32'(p6), 32'h0);
    tick();
    chk("t2_c_up", 32'(up6), 32'h1);
    chk("t2_c_op", 32'(op6), 32'hF);
    chk("t2_c_ch", 32'(ch6), 32'h4);
    count_pulses(23, p6, p3);
    chk("t2_gap_c",  32'(p6),    32'h0);
    chk("t2_busy_c", 32'(busy6), 32'h1);
    tick();
    chk("t2_idle", 32'(busy6), 32'h0);

    // Pulse coinciding with the commit slot: that commit is ignored
    goto_slot(21);
    wr(8'h35);
    wr(8'h86);
    chk("t3_x_up", 32'(up6), 32'h1);
    chk("t3_x_op", 32'(op6), 32'h3);
    chk("t3_x_ch", 32'(ch6), 32'h5);
    tick();
    chk("t3_ignored_up",   32'(up6),   32'h0);
    chk("t3_ignored_busy", 32'(busy6), 32'h1);
    count_pulses(23, p6, p3);
    chk("t3_full_frame", 32'(p6), 32'h0);
    tick();
    chk("t3_y_up", 32'(up6), 32'h1);
    chk("t3_y_op", 32'(op6), 32'h8);
    chk("t3_y_ch", 32'(ch6), 32'h6);
    goto_slot(23);
    tick();
    chk("t3_idle", 32'(busy6), 32'h0);

    // Overflow with no commit reachable
    slot_run = 1'b0;
    slot     = 0;
    drive_slot();
    wr(8'h40);
    chk("t4_busy", 32'(busy6), 32'h1);
    tick();
    chk("t4_prime_up", 32'(up6), 32'h1);
    wr(8'h11);
    wr(8'h22);
    wr(8'h44);
    chk("t4_full3", 32'(full6), 32'h0);
    wr(8'h85);
    chk("t4_full4", 32'(full6), 32'h1);
    chk("t4_ovf0",  32'(ovf6),  32'h0);
    wr(8'hF6);
    chk("t4_ovf_set",   32'(ovf6),  32'h1);
    chk("t4_full_keep", 32'(full6), 32'h1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t4_ovf_clr", 32'(ovf6), 32'h0);
    clr_ovf = 1'b1;
    wr(8'hF6);
    clr_ovf = 1'b0;
    chk("t4_set_wins", 32'(ovf6), 32'h1);
    clk_en  = 1'b0;
    clr_ovf = 1'b1;
    tick();
    chk("t4_clk_en_hold", 32'(ovf6), 32'h1);
    clk_en = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t4_ovf_clr2", 32'(ovf6), 32'h0);
    slot_run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      goto_slot(23);
      tick();
      chk("t4_drain_up", 32'(up6), 32'h1);
      chk("t4_drain_op", 32'(op6), 32'(drain_exp[i][7:4]));
      chk("t4_drain_ch", 32'(ch6), 32'(drain_exp[i][2:0]));
      if (i == 0) chk("t4_full_drop", 32'(full6), 32'h0);
    end
    goto_slot(23);
    tick();
    chk("t4_idle", 32'(busy6), 32'h0);

    // Async reset while waiting with two entries queued
    wr(8'h10);
    wr(8'h21);
    wr(8'h42);
    wr(8'h54);
    goto_slot(23);
    tick();
    chk("t6_up_before", 32'(up6), 32'h1);
    chk("t6_op_before", 32'(op6), 32'h2);
    chk("t6_ch_before", 32'(ch6), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_up",   32'(up6),   32'h0);
    chk("t6_op",   32'(op6),   32'h0);
    chk("t6_ch",   32'(ch6),   32'h0);
    chk("t6_busy", 32'(busy6), 32'h0);
    chk("t6_full", 32'(full6), 32'h0);
    chk("t6_ovf",  32'(ovf6),  32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    slot  = 0;
    drive_slot();
    count_pulses(30, p6, p3);
    chk("t6_no_pulse6", 32'(p6),    32'h0);
    chk("t6_no_pulse3", 32'(p3),    32'h0);
    chk("t6_busy_post", 32'(busy6), 32'h0);

    // Channel validation
    wr(8'hF3);
    wr(8'hF7);
    tick();
    chk("t5_busy6", 32'(busy6), 32'h0);
    chk("t5_ovf6",  32'(ovf6),  32'h0);
    chk("t5_up6",   32'(up6),   32'h0);
    chk("t5_busy3", 32'(busy3), 32'h0);
    chk("t5_ovf3",  32'(ovf3),  32'h0);
    wr(8'hF4);
    chk("t5_ch4_3ch", 32'(busy3), 32'h0);
    chk("t5_ch4_6ch", 32'(busy6), 32'h1);
    wr(8'hA2);
    chk("t5_3ch_push", 32'(busy3), 32'h1);
    tick();
    chk("t5_3ch_up", 32'(up3), 32'h1);
    chk("t5_3ch_op", 32'(op3), 32'hA);
    chk("t5_3ch_ch", 32'(ch3), 32'h2);
    goto_slot(20);
    chk("t5_3ch_wait", 32'(busy3), 32'h1);
    tick();
    chk("t5_3ch_commit", 32'(busy3), 32'h0);
    chk("t5_3ch_ovf",    32'(ovf3),  32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
